// File: rtl/stock_manager.sv
// Stock counters for the vending machine slots, shared by the bulk-reload and vend paths.
// Optional low-stock pulse is compiled in when STOCK_LOW_STOCK_EN is defined.
module stock_manager #(
  parameter int NUM_SLOTS  = 20,
  parameter int CNT_W      = 4,
  parameter int FULL_CNT   = 10,
  parameter int LOW_THRESH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RELOAD_REQ,
  input  logic             VEND_REQ,
  input  logic [4:0]       VEND_SLOT,
  input  logic [4:0]       QUERY_SLOT,
  output logic [CNT_W-1:0] QUERY_CNT,
  output logic             VEND_ACK,
  output logic             SOLD_OUT,
  output logic             BAD_SLOT,
  output logic             RELOAD_DONE,
  output logic             BUSY,
  output logic             LOW_STOCK
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RELOAD = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [4:0]       LAST_SLOT = 5'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_VAL  = CNT_W'(FULL_CNT);

  // Both the reload value and the threshold have to be representable in a counter.
  if (FULL_CNT >= (1 << CNT_W) || LOW_THRESH >= (1 << CNT_W)) begin : g_bad_param
    $error("stock_manager: FULL_CNT/LOW_THRESH do not fit in CNT_W bits");
  end

  logic [1:0]       state;
  logic [4:0]       idx;
  logic [4:0]       slot;
  logic [CNT_W-1:0] counts [NUM_SLOTS];

  logic             slot_bad;
  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_dec;
  logic             low_on_ack;
  logic             low_on_sold;

  assign slot_bad = (slot > LAST_SLOT);
  assign slot_cnt = slot_bad ? '0 : counts[slot];
  assign slot_dec = slot_cnt - CNT_W'(1);

`ifdef STOCK_LOW_STOCK_EN
  localparam logic [CNT_W-1:0] LOW_VAL = CNT_W'(LOW_THRESH);
  assign low_on_ack  = (slot_dec <= LOW_VAL);
  assign low_on_sold = 1'b1;
`else
  assign low_on_ack  = 1'b0;
  assign low_on_sold = 1'b0;
`endif

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      idx         <= '0;
      slot        <= '0;
      QUERY_CNT   <= '0;
      VEND_ACK    <= 1'b0;
      SOLD_OUT    <= 1'b0;
      BAD_SLOT    <= 1'b0;
      RELOAD_DONE <= 1'b0;
      LOW_STOCK   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        counts[i] <= '0;
      end
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      VEND_ACK    <= 1'b0;
      SOLD_OUT    <= 1'b0;
      BAD_SLOT    <= 1'b0;
      RELOAD_DONE <= 1'b0;
      LOW_STOCK   <= 1'b0;
      QUERY_CNT   <= (QUERY_SLOT > LAST_SLOT) ? '0 : counts[QUERY_SLOT];

      case (state)
        IDLE: begin
          if (RELOAD_REQ) begin
            idx   <= '0;
            state <= RELOAD;
          end else if (VEND_REQ) begin
            slot  <= VEND_SLOT;
            state <= CHECK;
          end
        end
        RELOAD: begin
          counts[idx] <= FULL_VAL;
          idx         <= idx + 5'd1;
          if (idx == LAST_SLOT) begin
            RELOAD_DONE <= 1'b1;
            state       <= DONE;
          end
        end
        CHECK: begin
          if (slot_bad) begin
            BAD_SLOT <= 1'b1;
          end else if (slot_cnt == '0) begin
            SOLD_OUT  <= 1'b1;
            LOW_STOCK <= low_on_sold;
          end else begin
            counts[slot] <= slot_dec;
            VEND_ACK     <= 1'b1;
            LOW_STOCK    <= low_on_ack;
          end
          state <= DONE;
        end
        DONE: begin
          // Requests ignored here so the requester has a cycle to drop them.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stock_manager.md
Name: stock_manager

Overview:
- Inventory controller for the vending machine's 20 item slots.
- Owns the per-slot stock counters and sequences the two requesters that share them: the bulk reload path and the vend (decrement) path.
- Arbitrates between the two, and reports sold-out and bad-slot outcomes back to the transaction FSM.
- Provides a registered read port for display/diagnostics.

Parameters:
NUM_SLOTS, 20, number of item slots (slot codes 0..NUM_SLOTS-1)
CNT_W, 4, width of each stock counter
FULL_CNT, 10, value written to every slot on reload
LOW_THRESH, 2, low-stock threshold (used only with LOW_STOCK_EN)

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
RELOAD_REQ  in  1  level request to refill all slots
VEND_REQ  in  1  level request to decrement one slot
VEND_SLOT  in  5  slot code, sampled with VEND_REQ
QUERY_SLOT  in  5  slot code for the read port
QUERY_CNT  out  CNT_W  registered stock of QUERY_SLOT
VEND_ACK  out  1  1-cycle pulse: decrement done
SOLD_OUT  out  1  1-cycle pulse: slot count was 0, no change
BAD_SLOT  out  1  1-cycle pulse: VEND_SLOT >= NUM_SLOTS
RELOAD_DONE  out  1  1-cycle pulse: reload complete
BUSY  out  1  high whenever state != IDLE
LOW_STOCK  out  1  low-stock pulse (see Optional Feature)

Behaviour:
- Reset:
  - On an edge with RESET=1: state=IDLE, all counters=0, slot index=0.
  - All outputs 0, including QUERY_CNT.
  - Reset mid-reload or mid-vend aborts the operation; no pulse is issued.
- States: IDLE, RELOAD, CHECK, DONE.
- IDLE:
  - RELOAD_REQ=1 -> RELOAD with idx=0. Reload has priority when both requests are high.
  - Else VEND_REQ=1 -> capture VEND_SLOT -> CHECK.
  - Else stay in IDLE.
  - A VEND_REQ that loses arbitration stays pending and is served after reload completes.
- RELOAD:
  - Each cycle: counts[idx] <= FULL_CNT, idx <= idx+1.
  - When idx==NUM_SLOTS-1: write, set RELOAD_DONE=1, go to DONE.
  - Total NUM_SLOTS cycles in RELOAD; requests in this window are ignored.
- CHECK (one cycle). Exactly one pulse is registered, visible the following cycle:
  - captured slot >= NUM_SLOTS -> BAD_SLOT=1, no counter change.
  - counts[slot]==0 -> SOLD_OUT=1, no change. Counters never underflow.
  - else counts[slot] <= counts[slot]-1, VEND_ACK=1.
  - Then go to DONE.
- DONE:
  - Clear all pulses, return to IDLE.
  - Requests are ignored in DONE, which gives requesters one cycle to drop the request.
  - A request still high back in IDLE is a new request.
- Latency:
  - VEND_REQ sampled in IDLE at edge N -> response pulse high from edge N+1 to edge N+2.
  - RELOAD_REQ sampled at edge N -> RELOAD_DONE high from edge N+NUM_SLOTS to N+NUM_SLOTS+1.
- Handshake: requester holds REQ and the slot stable until it sees any response pulse, then deasserts.
- QUERY_CNT:
  - Every edge: QUERY_CNT <= counts[QUERY_SLOT], or 0 if QUERY_SLOT >= NUM_SLOTS.
  - Reflects counter values before the same-edge write (one-cycle lag after a write).
- BUSY: registered with the state; high in RELOAD, CHECK and DONE.
- Width: counters are CNT_W bits. FULL_CNT must fit in CNT_W bits; no saturation logic is needed beyond the zero check.

Optional Feature:
- Macro: STOCK_LOW_STOCK_EN.
- Defined: in CHECK on a successful decrement, LOW_STOCK=1 (pulsed with VEND_ACK) if the post-decrement count <= LOW_THRESH. LOW_STOCK also pulses with SOLD_OUT.
- Undefined: LOW_STOCK tied 0 and the comparison logic is absent. The port stays in the interface.

Test Plan:
- Reset, then query slot 7 -> QUERY_CNT=0. Vend slot 7 -> SOLD_OUT pulse 2 cycles after request, VEND_ACK=0.
- RELOAD_REQ for 1 cycle -> BUSY high 21 cycles, RELOAD_DONE pulse 20 cycles after sample. Query slots 0, 19 -> 10; query slot 20 -> 0.
- After reload, vend slot 5 ten times -> ten VEND_ACK pulses, QUERY_CNT(5) goes 9..0. Eleventh vend -> SOLD_OUT, count stays 0.
- VEND_REQ with VEND_SLOT=22 -> BAD_SLOT pulse, no counter changes (query all 20 slots unchanged).
- RELOAD_REQ and VEND_REQ (slot 3) asserted on the same edge, slot 3 previously 4 -> reload runs first; then VEND_ACK, and QUERY_CNT(3)=9.
- RESET asserted on the 8th RELOAD cycle -> next cycle all outputs 0, all counts 0, no RELOAD_DONE. With STOCK_LOW_STOCK_EN: reload, vend slot 1 eight times -> LOW_STOCK pulses on 8th ack (count 2), not on 7th (count 3).
